// File: rtl/ysyx_22050039_seq.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/wb control strobes,
// fetch timeout detection, sticky halt/error and activity counters.
module ysyx_22050039_seq #(
  parameter int unsigned INST_LEN = 32,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                inst_valid,
  input  logic [INST_LEN-1:0] inst_in,
  input  logic [2:0]          func,
  input  logic                dec_pc_wen,
  input  logic                mem_ack,
  output logic                inst_req,
  output logic [INST_LEN-1:0] inst_out,
  output logic                mem_req,
  output logic                mem_we,
  output logic                reg_wen,
  output logic                pc_wen,
  output logic                pc_sel,
  output logic                halt,
  output logic                error,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         inst_cnt
);

  localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt, StError
  } state_e;

  localparam logic [2:0] FuncSd     = 3'd4;
  localparam logic [2:0] FuncEbreak = 3'd6;
  localparam logic [2:0] FuncInval  = 3'd7;

  state_e              state_q;
  logic [WaitW-1:0]    wait_q;
  logic [INST_LEN-1:0] inst_q;
  logic [31:0]         cycle_q;
  logic [31:0]         icnt_q;
  logic                active;

  assign active = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExec) ||
                  (state_q == StMem) || (state_q == StWb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wait_q  <= '0;
      inst_q  <= '0;
      cycle_q <= '0;
      icnt_q  <= '0;
    end else begin
      if (active) cycle_q <= cycle_q + 32'd1;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFetch;
            wait_q  <= '0;
          end
        end
        StFetch: begin
          // A response in the final allowed cycle still wins over the timeout.
          if (inst_valid) begin
            inst_q  <= inst_in;
            state_q <= StDecode;
          end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
            state_q <= StError;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StDecode: begin
          if (func == FuncEbreak)     state_q <= StHalt;
          else if (func == FuncInval) state_q <= StError;
          else                        state_q <= StExec;
        end
        StExec:   state_q <= (func == FuncSd) ? StMem : StWb;
        StMem:    if (mem_ack) state_q <= StWb;
        StWb: begin
          icnt_q  <= icnt_q + 32'd1;
          wait_q  <= '0;
          state_q <= StFetch;
        end
        StHalt, StError: state_q <= state_q;
      endcase
    end
  end

  // Strobes depend only on the registered state (and decoder info), so reset clears them at once.
  always_comb begin
    inst_req = (state_q == StFetch);
    mem_req  = (state_q == StMem);
    mem_we   = (state_q == StMem);
    pc_wen   = (state_q == StWb);
    pc_sel   = (state_q == StWb) && dec_pc_wen;
    reg_wen  = (state_q == StWb) &&
               ((func == 3'd0) || (func == 3'd1) || (func == 3'd2) ||
                (func == 3'd3) || (func == 3'd5));
    halt     = (state_q == StHalt);
    error    = (state_q == StError);
  end

  assign inst_out  = inst_q;
  assign cycle_cnt = cycle_q;
  assign inst_cnt  = icnt_q;

endmodule

// File: tb/tb_ysyx_22050039_seq.sv
// Directed bench for the sequencer: instruction classes, timeout boundary,
// terminal states and asynchronous reset.
module tb_ysyx_22050039_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        inst_valid;
  logic [31:0] inst_in;
  logic [2:0]  func;
  logic        dec_pc_wen;
  logic        mem_ack;
  logic        inst_req;
  logic [31:0] inst_out;
  logic        mem_req;
  logic        mem_we;
  logic        reg_wen;
  logic        pc_wen;
  logic        pc_sel;
  logic        halt;
  logic        error;
  logic [31:0] cycle_cnt;
  logic [31:0] inst_cnt;

  int n_total = 0;
  int n_bad   = 0;

  ysyx_22050039_seq #(.INST_LEN(32), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .inst_valid (inst_valid),
    .inst_in    (inst_in),
    .func       (func),
    .dec_pc_wen (dec_pc_wen),
    .mem_ack    (mem_ack),
    .inst_req   (inst_req),
    .inst_out   (inst_out),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .reg_wen    (reg_wen),
    .pc_wen     (pc_wen),
    .pc_sel     (pc_sel),
    .halt       (halt),
    .error      (error),
    .cycle_cnt  (cycle_cnt),
    .inst_cnt   (inst_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packs the control strobes: {inst_req, mem_req, mem_we, reg_wen, pc_wen, pc_sel, halt, error}
  function automatic logic [31:0] strobes();
    return {24'd0, inst_req, mem_req, mem_we, reg_wen, pc_wen, pc_sel, halt, error};
  endfunction

  // Called while in FETCH: presents an instruction and moves into DECODE.
  task automatic issue(input logic [31:0] inst, input logic [2:0] f, input logic jmp);
    inst_valid = 1'b1;
    inst_in    = inst;
    func       = f;
    dec_pc_wen = jmp;
    step();
    inst_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; inst_valid = 1'b0; inst_in = '0;
    func = 3'd0; dec_pc_wen = 1'b0; mem_ack = 1'b0;
    step(); step();
    check("rst_strobes", strobes(), 32'h00);
    check("rst_inst_out", inst_out, 32'h0);
    check("rst_cycle", cycle_cnt, 32'd0);
    check("rst_icnt", inst_cnt, 32'd0);

    rst = 1'b0;
    step(); step();
    check("idle_hold", strobes(), 32'h00);

    // addi: WB in the fourth cycle after FETCH entry
    start = 1'b1; step(); start = 1'b0;
    check("addi_fetch", strobes(), 32'h80);
    issue(32'h0010_0093, 3'd0, 1'b0);
    check("addi_decode", strobes(), 32'h00);
    check("addi_inst_out", inst_out, 32'h0010_0093);
    step();
    check("addi_exec", strobes(), 32'h00);
    step();
    check("addi_wb", strobes(), 32'h18);
    step();
    check("addi_next_fetch", strobes(), 32'h80);
    check("addi_cycle", cycle_cnt, 32'd4);
    check("addi_icnt", inst_cnt, 32'd1);

    // sd: three MEM cycles, ack in the third
    issue(32'h0011_3023, 3'd4, 1'b0);
    step();
    check("sd_exec", strobes(), 32'h00);
    step();
    check("sd_mem1", strobes(), 32'h60);
    step();
    check("sd_mem2", strobes(), 32'h60);
    step();
    mem_ack = 1'b1; #1;
    check("sd_mem3_ack", strobes(), 32'h60);
    step();
    mem_ack = 1'b0;
    check("sd_wb", strobes(), 32'h08);
    step();
    check("sd_cycle", cycle_cnt, 32'd11);
    check("sd_icnt", inst_cnt, 32'd2);

    // jal: jump target selected, GPR written; inst_out holds while inst_in changes
    issue(32'h0080_00ef, 3'd5, 1'b1);
    inst_in = 32'hdead_beef;
    step();
    check("jal_inst_hold", inst_out, 32'h0080_00ef);
    step();
    check("jal_wb", strobes(), 32'h1c);
    step();
    dec_pc_wen = 1'b0;
    check("jal_cycle", cycle_cnt, 32'd15);
    check("jal_icnt", inst_cnt, 32'd3);

    // Valid arriving in the 16th FETCH cycle goes to DECODE
    for (int i = 0; i < 15; i++) step();
    check("edge_fetch16", strobes(), 32'h80);
    issue(32'h0000_0013, 3'd0, 1'b0);
    check("edge_decode", strobes(), 32'h00);
    check("edge_inst_out", inst_out, 32'h0000_0013);
    step(); step(); step();

    // ebreak: halts, start ignored, counters frozen
    issue(32'h0010_0073, 3'd6, 1'b0);
    step();
    check("ebreak_halt", strobes(), 32'h02);
    start = 1'b1; step(); step(); start = 1'b0;
    check("ebreak_sticky", strobes(), 32'h02);
    check("ebreak_cycle", cycle_cnt, 32'd36);
    check("ebreak_icnt", inst_cnt, 32'd4);

    // Asynchronous reset between edges
    #2 rst = 1'b1; #1;
    check("async_rst_halt", strobes(), 32'h00);
    check("async_rst_cycle", cycle_cnt, 32'd0);
    step(); rst = 1'b0;

    // Timeout: 16 FETCH cycles without valid
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("to_fetch16", strobes(), 32'h80);
    step();
    check("to_error", strobes(), 32'h01);
    check("to_cycle", cycle_cnt, 32'd16);
    start = 1'b1; step(); step(); start = 1'b0;
    check("to_sticky", strobes(), 32'h01);

    // Reset mid-MEM, then restart from zero counts
    rst = 1'b1; step(); rst = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    issue(32'h0011_3023, 3'd4, 1'b0);
    step(); step();
    check("mid_mem", strobes(), 32'h60);
    #2 rst = 1'b1; #1;
    check("mid_mem_rst", strobes(), 32'h00);
    check("mid_mem_rst_inst", inst_out, 32'h0);
    step(); rst = 1'b0;
    step();
    check("post_rst_idle", strobes(), 32'h00);
    start = 1'b1; step(); start = 1'b0;
    issue(32'h0010_0093, 3'd0, 1'b0);
    step(); step();
    check("restart_wb", strobes(), 32'h18);
    step();
    check("restart_cycle", cycle_cnt, 32'd4);
    check("restart_icnt", inst_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
